phv_collect: RTL and testbench
==============================

PHV_COLLECT -- requirements
Module: phv_collect

Interface
REQ-001 SHALL have parameter NUM_CONT, default 8, number of ALU containers gathered per PHV.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each container.
REQ-003 SHALL have parameter META_WIDTH, default 256, width of the pass-through metadata word.
REQ-004 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is synchronous, active-low.
REQ-006 SHALL have port container_in, input, NUM_CONT*DATA_WIDTH; slot i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port container_in_valid, input, NUM_CONT; per-ALU one-cycle result pulse.
REQ-008 SHALL have port alu_ready, output, NUM_CONT; per-ALU grant, driven to each ALU's ready_in.
REQ-009 SHALL have port meta_in, input, META_WIDTH; metadata accompanying the PHV from upstream.
REQ-010 SHALL have port meta_valid, input, 1; one-cycle pulse qualifying meta_in.
REQ-011 SHALL have port meta_ready, output, 1; high when a meta_in capture is accepted.
REQ-012 SHALL have port phv_out, output, META_WIDTH+NUM_CONT*DATA_WIDTH, registered; {meta, container[NUM_CONT-1..0]}.
REQ-013 SHALL have port phv_out_valid, output, 1, registered.
REQ-014 SHALL have port ready_in, input, 1; downstream accept.
REQ-015 SHALL have port err_dup, output, 1, sticky; a valid pulse arrived on an already-filled slot.

Function
REQ-016 SHALL implement states COLLECT and OUTPUT.
REQ-017 SHALL hold a fill bit per container slot plus one for meta.
REQ-018 In COLLECT, SHALL drive alu_ready[i] = !fill[i] and meta_ready = !fill_meta, decoded combinationally from registers; in OUTPUT both SHALL be all zeros.
REQ-019 In COLLECT, container_in_valid[i] with fill[i]=0 SHALL capture slot i and set fill[i] at the next edge; same rule for meta.
REQ-020 Any number of slots, including all slots and meta, SHALL be capturable in the same cycle.
REQ-021 A valid pulse on a filled slot, or any valid pulse in OUTPUT, SHALL be ignored (data unchanged) and SHALL set err_dup.
REQ-022 When all fill bits would be 1 after the current edge, SHALL move to OUTPUT and assert phv_out_valid with the assembled PHV on that same edge; latency from last capture cycle to phv_out_valid is 1 cycle.
REQ-023 In OUTPUT, phv_out and phv_out_valid SHALL stay stable until ready_in=1.
REQ-024 On the OUTPUT cycle with ready_in=1, SHALL clear phv_out_valid and all fill bits and return to COLLECT at the next edge; alu_ready is high again the cycle after.
REQ-025 Throughput: at most one PHV per 2 cycles; back-to-back PHVs SHALL NOT be merged or dropped.
REQ-026 Slot data registers SHALL retain old contents after output; only fill bits gate completion.

Reset
REQ-027 While rst_n=0 at an edge: state=COLLECT, all fill bits=0, phv_out=0, phv_out_valid=0, err_dup=0.
REQ-028 Reset mid-collection or mid-OUTPUT SHALL discard partial or pending PHVs; alu_ready and meta_ready read all ones the cycle after reset.

Structure
REQ-029 State encoding, DATA_WIDTH/NUM_CONT/META_WIDTH defaults, and PHV field offsets SHALL live in the shared rmt package.
REQ-030 SHALL be a single module with no sub-modules; slot registers are generated per container.

Verification
REQ-031 Reset then all 8 ALUs and meta pulse in one cycle with container i=0x100+i, ready_in=1 -> phv_out_valid one cycle later, slots 0x100..0x107, valid lasts 1 cycle.
REQ-032 Containers arrive one per cycle in order 7..0, meta first, ready_in=1 -> phv_out_valid exactly 1 cycle after slot 0; alu_ready[i] drops the cycle after each capture.
REQ-033 Complete PHV with ready_in=0 for 5 cycles -> phv_out stable and valid for 6 cycles; alu_ready=0 throughout; single transfer when ready_in rises.
REQ-034 Slot 3 pulses 0xAAAA then 0xBBBB before completion -> PHV carries 0xAAAA; err_dup=1 and stays set until reset.
REQ-035 7 of 8 slots filled, then rst_n=0 for 1 cycle, then full set with new values -> exactly one PHV with only the new values.
REQ-036 Two complete PHVs back-to-back with ready_in=1 -> two distinct phv_out_valid pulses, second data correct, err_dup=0.

Source files
------------

// File: rtl/rmt_pkg.sv
`default_nettype none
// ============================================================================
// rmt_pkg : shared RMT types, default geometry and PHV field offsets
// Rev 1.0
// ============================================================================
package rmt_pkg;

  localparam int RMT_NUM_CONT   = 8;
  localparam int RMT_DATA_WIDTH = 32;
  localparam int RMT_META_WIDTH = 256;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } phv_state_e;

  // PHV layout: containers packed from bit 0 upward, metadata above them.
  function automatic int cont_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

  function automatic int meta_lsb(input int nc, input int dw);
    return nc * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phv_collect.sv
`default_nettype none
// ============================================================================
// phv_collect : gathers per-ALU container results plus metadata into one PHV
// Rev 1.0
// ============================================================================
module phv_collect
  import rmt_pkg::*;
#(
  parameter int NUM_CONT   = RMT_NUM_CONT,
  parameter int DATA_WIDTH = RMT_DATA_WIDTH,
  parameter int META_WIDTH = RMT_META_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CONT*DATA_WIDTH-1:0]         container_in,
  input  logic [NUM_CONT-1:0]                    container_in_valid,
  output logic [NUM_CONT-1:0]                    alu_ready,
  input  logic [META_WIDTH-1:0]                  meta_in,
  input  logic                                   meta_valid,
  output logic                                   meta_ready,
  output logic [META_WIDTH+NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                                   phv_out_valid,
  input  logic                                   ready_in,
  output logic                                   err_dup
);

  localparam int CONT_BITS = NUM_CONT * DATA_WIDTH;
  localparam int META_LSB  = meta_lsb(NUM_CONT, DATA_WIDTH);

  phv_state_e              state, state_nx;
  logic [NUM_CONT-1:0]     fill, fill_nx, cap;
  logic                    fill_meta, fill_meta_nx, cap_meta;
  logic [DATA_WIDTH-1:0]   slot_q [NUM_CONT];
  logic [CONT_BITS-1:0]    slot_nx;
  logic [META_WIDTH-1:0]   meta_q, meta_nx;
  logic                    dup_hit, load_phv, release_phv;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    cap          = '0;
    cap_meta     = 1'b0;
    fill_nx      = fill;
    fill_meta_nx = fill_meta;
    dup_hit      = 1'b0;
    load_phv     = 1'b0;
    release_phv  = 1'b0;
    alu_ready    = '0;
    meta_ready   = 1'b0;
    case (state)
      ST_COLLECT: begin
        alu_ready    = ~fill;
        meta_ready   = ~fill_meta;
        cap          = container_in_valid & ~fill;
        cap_meta     = meta_valid & ~fill_meta;
        dup_hit      = (|(container_in_valid & fill)) | (meta_valid & fill_meta);
        fill_nx      = fill | cap;
        fill_meta_nx = fill_meta | cap_meta;
        if ((&fill_nx) && fill_meta_nx) begin
          state_nx = ST_OUTPUT;
          load_phv = 1'b1;
        end
      end
      ST_OUTPUT: begin
        // Everything arriving while a PHV is parked is a protocol violation.
        dup_hit = (|container_in_valid) | meta_valid;
        if (ready_in) begin
          state_nx     = ST_COLLECT;
          fill_nx      = '0;
          fill_meta_nx = 1'b0;
          release_phv  = 1'b1;
        end
      end
      default: state_nx = ST_COLLECT;
    endcase
  end

  for (genvar i = 0; i < NUM_CONT; i++) begin : g_slot
    localparam int LSB = cont_lsb(i, DATA_WIDTH);

    assign slot_nx[LSB +: DATA_WIDTH] = cap[i] ? container_in[LSB +: DATA_WIDTH] : slot_q[i];

    // Data is not reset; only the fill bits decide completion.
    always_ff @(posedge clk) begin
      slot_q[i] <= slot_nx[LSB +: DATA_WIDTH];
    end
  end

  assign meta_nx = cap_meta ? meta_in : meta_q;

  always_ff @(posedge clk) begin
    meta_q <= meta_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill          <= '0;
      fill_meta     <= 1'b0;
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      err_dup       <= 1'b0;
    end else begin
      fill      <= fill_nx;
      fill_meta <= fill_meta_nx;
      if (dup_hit) err_dup <= 1'b1;
      if (load_phv) begin
        phv_out[META_LSB +: META_WIDTH] <= meta_nx;
        phv_out[CONT_BITS-1:0]          <= slot_nx;
        phv_out_valid                   <= 1'b1;
      end else if (release_phv) begin
        phv_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phv_collect.sv
`default_nettype none
// ============================================================================
// tb_phv_collect : directed self-checking bench for phv_collect
// Rev 1.0
// ============================================================================
module tb_phv_collect;

  localparam int NC = 8;
  localparam int DW = 32;
  localparam int MW = 256;
  localparam int PW = MW + NC*DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC*DW-1:0] container_in;
  logic [NC-1:0]   container_in_valid;
  logic [NC-1:0]   alu_ready;
  logic [MW-1:0]   meta_in;
  logic            meta_valid;
  logic            meta_ready;
  logic [PW-1:0]   phv_out;
  logic            phv_out_valid;
  logic            ready_in;
  logic            err_dup;

  int checks = 0;
  int errors = 0;

  phv_collect dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .container_in       (container_in),
    .container_in_valid (container_in_valid),
    .alu_ready          (alu_ready),
    .meta_in            (meta_in),
    .meta_valid         (meta_valid),
    .meta_ready         (meta_ready),
    .phv_out            (phv_out),
    .phv_out_valid      (phv_out_valid),
    .ready_in           (ready_in),
    .err_dup            (err_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slots(input logic [31:0] base);
    for (int i = 0; i < NC; i++) container_in[i*DW +: DW] = base + 32'(i);
  endtask

  function automatic logic [PW-1:0] mk_phv(input logic [MW-1:0] m, input logic [31:0] base);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = base + 32'(i);
    v[PW-1 -: MW] = m;
    return v;
  endfunction

  logic [PW-1:0] exp_phv;
  logic [PW-1:0] held;
  logic [NC-1:0] exp_rdy;
  logic [MW-1:0] m1, m2, m3, m4, m5, m6, m7, m8;

  initial begin
    m1 = {8{32'hDEAD_0001}};
    m2 = {8{32'hBEEF_0002}};
    m3 = {8{32'hCAFE_0003}};
    m4 = {8{32'hF00D_0004}};
    m5 = {8{32'h5555_0005}};
    m6 = {8{32'h6666_0006}};
    m7 = {8{32'h7777_0007}};
    m8 = {8{32'h8888_0008}};
    rst_n = 1'b0;
    container_in = '0;
    container_in_valid = '0;
    meta_in = '0;
    meta_valid = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    check("rst_alu_ready", PW'(alu_ready), PW'(8'hFF));
    check("rst_meta_ready", PW'(meta_ready), PW'(1'b1));
    check("rst_phv_out", phv_out, '0);
    check("rst_valid", PW'(phv_out_valid), '0);
    check("rst_err", PW'(err_dup), '0);
    rst_n = 1'b1;

    // All eight ALUs and meta in a single cycle.
    set_slots(32'h100);
    meta_in = m1;
    container_in_valid = 8'hFF;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    check("one_cyc_valid", PW'(phv_out_valid), PW'(1'b1));
    check("one_cyc_data", phv_out, mk_phv(m1, 32'h100));
    check("one_cyc_rdy_out", PW'(alu_ready), '0);
    tick();
    check("one_cyc_valid_drop", PW'(phv_out_valid), '0);
    check("one_cyc_rdy_back", PW'(alu_ready), PW'(8'hFF));

    // Meta first, then containers 7..0 one per cycle.
    set_slots(32'h200);
    meta_in = m2;
    meta_valid = 1'b1;
    tick();
    meta_valid = 1'b0;
    check("seq_meta_ready", PW'(meta_ready), '0);
    exp_rdy = 8'hFF;
    for (int i = NC-1; i >= 0; i--) begin
      container_in_valid = 8'(1 << i);
      tick();
      container_in_valid = '0;
      exp_rdy[i] = 1'b0;
      if (i != 0) begin
        check($sformatf("seq_rdy_%0d", i), PW'(alu_ready), PW'(exp_rdy));
        check($sformatf("seq_novalid_%0d", i), PW'(phv_out_valid), '0);
      end
    end
    check("seq_valid", PW'(phv_out_valid), PW'(1'b1));
    check("seq_data", phv_out, mk_phv(m2, 32'h200));
    tick();
    check("seq_valid_drop", PW'(phv_out_valid), '0);

    // Downstream stalls: output must hold.
    ready_in = 1'b0;
    set_slots(32'h300);
    meta_in = m3;
    container_in_valid = 8'hFF;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    held = phv_out;
    check("stall_data", held, mk_phv(m3, 32'h300));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_valid_%0d", k), PW'(phv_out_valid), PW'(1'b1));
      check($sformatf("stall_hold_%0d", k), phv_out, mk_phv(m3, 32'h300));
      check($sformatf("stall_rdy_%0d", k), PW'(alu_ready), '0);
    end
    ready_in = 1'b1;
    tick();
    check("stall_release", PW'(phv_out_valid), '0);
    check("stall_no_err", PW'(err_dup), '0);

    // Duplicate on slot 3: first value wins, error is sticky.
    set_slots(32'h400);
    container_in[3*DW +: DW] = 32'hAAAA;
    container_in_valid = 8'h08;
    tick();
    check("dup_first_ok", PW'(err_dup), '0);
    container_in[3*DW +: DW] = 32'hBBBB;
    tick();
    container_in_valid = '0;
    check("dup_err_set", PW'(err_dup), PW'(1'b1));
    meta_in = m4;
    container_in_valid = 8'hF7;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    exp_phv = mk_phv(m4, 32'h400);
    exp_phv[3*DW +: DW] = 32'hAAAA;
    check("dup_data", phv_out, exp_phv);
    tick();
    check("dup_err_sticky", PW'(err_dup), PW'(1'b1));

    // Partial PHV discarded by reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_err_clr", PW'(err_dup), '0);
    set_slots(32'h500);
    meta_in = m5;
    container_in_valid = 8'h7F;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    check("part_rdy", PW'(alu_ready), PW'(8'h80));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("part_rst_rdy", PW'(alu_ready), PW'(8'hFF));
    check("part_rst_meta_rdy", PW'(meta_ready), PW'(1'b1));
    set_slots(32'h600);
    meta_in = m6;
    container_in_valid = 8'hFF;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    check("part_new_valid", PW'(phv_out_valid), PW'(1'b1));
    check("part_new_data", phv_out, mk_phv(m6, 32'h600));
    tick();
    check("part_valid_drop", PW'(phv_out_valid), '0);
    tick();
    check("part_single", PW'(phv_out_valid), '0);

    // Two PHVs back-to-back.
    set_slots(32'h700);
    meta_in = m7;
    container_in_valid = 8'hFF;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    check("b2b_first_valid", PW'(phv_out_valid), PW'(1'b1));
    check("b2b_first_data", phv_out, mk_phv(m7, 32'h700));
    set_slots(32'h800);
    meta_in = m8;
    tick();
    check("b2b_gap", PW'(phv_out_valid), '0);
    container_in_valid = 8'hFF;
    meta_valid = 1'b1;
    tick();
    container_in_valid = '0;
    meta_valid = 1'b0;
    check("b2b_second_valid", PW'(phv_out_valid), PW'(1'b1));
    check("b2b_second_data", phv_out, mk_phv(m8, 32'h800));
    tick();
    check("b2b_end", PW'(phv_out_valid), '0);
    check("b2b_no_err", PW'(err_dup), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
